// File: rtl/ste_dmasnd_fetch_pkg.sv
// Shared constants for the STE DMA-sound fetch block: CPU register offsets,
// control bit positions and FSM state encodings.
package ste_dmasnd_fetch_pkg;

  localparam logic [5:0] OFS_CTRL    = 6'd0;
  localparam logic [5:0] OFS_START_H = 6'd1;
  localparam logic [5:0] OFS_START_M = 6'd2;
  localparam logic [5:0] OFS_START_L = 6'd3;
  localparam logic [5:0] OFS_CNT_H   = 6'd4;
  localparam logic [5:0] OFS_CNT_M   = 6'd5;
  localparam logic [5:0] OFS_CNT_L   = 6'd6;
  localparam logic [5:0] OFS_END_H   = 6'd7;
  localparam logic [5:0] OFS_END_M   = 6'd8;
  localparam logic [5:0] OFS_END_L   = 6'd9;

  localparam int CTRL_PLAY = 0;
  localparam int CTRL_LOOP = 1;
  localparam int CTRL_DONE = 7;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_WAIT  = 3'd1;
  localparam logic [2:0] ST_LOAD  = 3'd2;
  localparam logic [2:0] ST_CHECK = 3'd3;
  localparam logic [2:0] ST_END   = 3'd4;

endpackage

// File: rtl/ste_dmasnd_fetch_regs.sv
// CPU-visible DMA-sound registers: write decode, start/end shadows, working
// frame end copy and the byte-wide read mux. Frame-done bit under DMASND_FRAME_IRQ_EN.
module dmasnd_regs
  import ste_dmasnd_fetch_pkg::*;
#(
  parameter int ADDR_W = 22
) (
  input  logic              clk32,
  input  logic              resb,
  input  logic              CS,
  input  logic              RW,
  input  logic [6:1]        A,
  input  logic [15:0]       DIN,
  output logic [15:0]       DOUT,
  input  logic [ADDR_W-1:1] counter_i,
  input  logic              load_frame_i,
  input  logic              clr_play_i,
  output logic              play_o,
  output logic              loop_o,
  output logic              stop_wr_o,
  output logic [ADDR_W-1:1] start_sh_o,
  output logic [ADDR_W-1:1] end_sh_o,
  output logic [ADDR_W-1:1] frame_end_o
`ifdef DMASND_FRAME_IRQ_EN
  ,
  input  logic              set_done_i
`endif
);

  logic              cs_q;
  logic              play_q;
  logic              loop_q;
  logic [ADDR_W-1:1] start_sh_q;
  logic [ADDR_W-1:1] end_sh_q;
  logic [ADDR_W-1:1] frame_end_q;
  logic              wr_stb;
  logic              done_bit;
  logic [7:0]        rdata;
  logic              unused_din;

  // One write per CS assertion, however long the CPU holds the cycle.
  assign wr_stb     = CS & ~RW & ~cs_q;
  assign stop_wr_o  = wr_stb && (A == OFS_CTRL) && !DIN[CTRL_PLAY];
  assign unused_din = ^DIN[15:8];

  always_ff @(posedge clk32) begin
    // NOTE: state updates use <= so every register samples pre-edge values.
    if (!resb) begin
      cs_q        <= 1'b0;
      play_q      <= 1'b0;
      loop_q      <= 1'b0;
      start_sh_q  <= '0;
      end_sh_q    <= '0;
      frame_end_q <= '0;
    end else begin
      cs_q <= CS;
      if (load_frame_i) frame_end_q <= end_sh_q;
      if (clr_play_i)   play_q      <= 1'b0;
      // Placed after the FSM clear so a CPU ctrl write in the same cycle wins.
      if (wr_stb) begin
        case (A)
          OFS_CTRL: begin
            play_q <= DIN[CTRL_PLAY];
            loop_q <= DIN[CTRL_LOOP];
          end
          OFS_START_H: start_sh_q[ADDR_W-1:16] <= DIN[ADDR_W-17:0];
          OFS_START_M: start_sh_q[15:8]        <= DIN[7:0];
          OFS_START_L: start_sh_q[7:1]         <= DIN[7:1];
          OFS_END_H:   end_sh_q[ADDR_W-1:16]   <= DIN[ADDR_W-17:0];
          OFS_END_M:   end_sh_q[15:8]          <= DIN[7:0];
          OFS_END_L:   end_sh_q[7:1]           <= DIN[7:1];
          default: ;
        endcase
      end
    end
  end

`ifdef DMASND_FRAME_IRQ_EN
  logic done_q;
  logic rd_stb;

  assign rd_stb = CS & RW & ~cs_q;

  always_ff @(posedge clk32) begin
    if (!resb)                          done_q <= 1'b0;
    else if (set_done_i)                done_q <= 1'b1;
    else if (rd_stb && A == OFS_CTRL)   done_q <= 1'b0;
  end

  assign done_bit = done_q;
`else
  assign done_bit = 1'b0;
`endif

  always_comb begin
    // NOTE: default assignment first so no path through the case infers a latch.
    rdata = 8'h00;
    case (A)
      OFS_CTRL:    rdata = {done_bit, 5'b00000, loop_q, play_q};
      OFS_START_H: rdata = 8'(start_sh_q[ADDR_W-1:16]);
      OFS_START_M: rdata = start_sh_q[15:8];
      OFS_START_L: rdata = {start_sh_q[7:1], 1'b0};
      OFS_CNT_H:   rdata = 8'(counter_i[ADDR_W-1:16]);
      OFS_CNT_M:   rdata = counter_i[15:8];
      OFS_CNT_L:   rdata = {counter_i[7:1], 1'b0};
      OFS_END_H:   rdata = 8'(end_sh_q[ADDR_W-1:16]);
      OFS_END_M:   rdata = end_sh_q[15:8];
      OFS_END_L:   rdata = {end_sh_q[7:1], 1'b0};
      default:     rdata = 8'h00;
    endcase
  end

  assign DOUT        = {8'h00, rdata};
  assign play_o      = play_q;
  assign loop_o      = loop_q;
  assign start_sh_o  = start_sh_q;
  assign end_sh_o    = end_sh_q;
  assign frame_end_o = frame_end_q;

endmodule

// File: rtl/ste_dmasnd_fetch.sv
// STE DMA-sound fetch: frame FSM, word counter and arbiter/shifter handshake.
// Optional SINT frame interrupt and sticky done bit under DMASND_FRAME_IRQ_EN.
module ste_dmasnd_fetch
  import ste_dmasnd_fetch_pkg::*;
#(
  parameter int ADDR_W   = 22,
  parameter int LOAD_LEN = 4
) (
  input  logic              clk32,
  input  logic              resb,
  input  logic              CS,
  input  logic              RW,
  input  logic [6:1]        A,
  input  logic [15:0]       DIN,
  output logic [15:0]       DOUT,
  input  logic              SREQ,
  output logic              SND_REQ,
  input  logic              SND_ACK,
  output logic [ADDR_W-1:1] SND_ADDR,
  output logic              SLOAD_N,
  output logic              SACTIVE
`ifdef DMASND_FRAME_IRQ_EN
  ,
  output logic              SINT
`endif
);

  localparam int                LW        = $clog2(LOAD_LEN);
  localparam logic [LW-1:0]     LOAD_LAST = LW'(LOAD_LEN - 1);
  localparam logic [ADDR_W-1:1] WORD_STEP = (ADDR_W-1)'(1);

  logic [2:0]        state_q,   state_d;
  logic [ADDR_W-1:1] cnt_q,     cnt_d;
  logic [ADDR_W-1:1] addr_q,    addr_d;
  logic [LW-1:0]     lcnt_q,    lcnt_d;
  logic              sload_n_q, sload_n_d;
  logic              sactive_q, sactive_d;

  logic              play, loop, stop_wr;
  logic [ADDR_W-1:1] start_sh, end_sh, frame_end;
  logic              load_frame, clr_play, zero_len, snd_req;

  dmasnd_regs #(.ADDR_W(ADDR_W)) u_regs (
    .clk32        (clk32),
    .resb         (resb),
    .CS           (CS),
    .RW           (RW),
    .A            (A),
    .DIN          (DIN),
    .DOUT         (DOUT),
    .counter_i    (cnt_q),
    .load_frame_i (load_frame),
    .clr_play_i   (clr_play),
    .play_o       (play),
    .loop_o       (loop),
    .stop_wr_o    (stop_wr),
    .start_sh_o   (start_sh),
    .end_sh_o     (end_sh),
    .frame_end_o  (frame_end)
`ifdef DMASND_FRAME_IRQ_EN
    ,
    .set_done_i   (state_q == ST_END)
`endif
  );

  // The counter is loaded straight from the start shadow and acts as the working start copy.
  assign zero_len = (start_sh == end_sh);
  assign snd_req  = (state_q == ST_WAIT) & SREQ & play;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    lcnt_d     = lcnt_q;
    sload_n_d  = sload_n_q;
    sactive_d  = sactive_q;
    load_frame = 1'b0;
    clr_play   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // SACTIVE is cleared while parked here; END leaves it as it was.
        sactive_d = 1'b0;
        if (play) begin
          load_frame = 1'b1;
          cnt_d      = start_sh;
          sactive_d  = 1'b1;
          state_d    = zero_len ? ST_END : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!play) begin
          sactive_d = 1'b0;
          state_d   = ST_IDLE;
        end else if (snd_req && SND_ACK) begin
          addr_d    = cnt_q;
          sload_n_d = 1'b0;
          lcnt_d    = '0;
          state_d   = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (lcnt_q == LOAD_LAST) begin
          sload_n_d = 1'b1;
          cnt_d     = cnt_q + WORD_STEP;
          if (!play) begin
            sactive_d = 1'b0;
            state_d   = ST_IDLE;
          end else begin
            state_d = ST_CHECK;
          end
        end else begin
          lcnt_d = lcnt_q + LW'(1);
        end
      end
      ST_CHECK: begin
        if (cnt_q == frame_end) begin
          sactive_d = 1'b0;
          state_d   = ST_END;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_END: begin
        if (loop && play && !stop_wr) begin
          load_frame = 1'b1;
          cnt_d      = start_sh;
          sactive_d  = 1'b1;
          state_d    = zero_len ? ST_END : ST_WAIT;
        end else begin
          clr_play = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk32) begin
    if (!resb) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      lcnt_q    <= '0;
      sload_n_q <= 1'b1;
      sactive_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      lcnt_q    <= lcnt_d;
      sload_n_q <= sload_n_d;
      sactive_q <= sactive_d;
    end
  end

  assign SND_REQ  = snd_req;
  assign SND_ADDR = addr_q;
  assign SLOAD_N  = sload_n_q;
  assign SACTIVE  = sactive_q;
`ifdef DMASND_FRAME_IRQ_EN
  assign SINT     = (state_q == ST_END);
`endif

endmodule
